// File: rtl/npc_redirect_ctrl.sv
// Redirect arbiter feeding the PC register: picks exc > eret > branch and holds
// a redirect that arrives during a stall until the first unstalled cycle.
module npc_redirect_ctrl #(
    parameter int             AW         = 32,
    parameter logic [AW-1:0]  EXC_VECTOR = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          br_req,
    input  logic [AW-1:0] br_target,
    input  logic          exc_req,
    input  logic          eret_req,
    input  logic [AW-1:0] epc,
    output logic [AW-1:0] npc,
    output logic          clr,
    output logic          flush_f,
    output logic          pending
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [1:0] RANK_BR   = 2'd0;
    localparam logic [1:0] RANK_ERET = 2'd1;
    localparam logic [1:0] RANK_EXC  = 2'd2;

    state_t        state_reg, state_next;
    logic [1:0]    p_rank_reg, p_rank_next;
    logic [AW-1:0] p_target_reg, p_target_next;

    logic          new_valid;
    logic [1:0]    new_rank;
    logic [AW-1:0] new_target;
    logic          new_beats_stored;
    logic [1:0]    win_rank;

    // Highest-ranked request arriving this cycle.
    always_comb begin
        new_valid  = br_req | eret_req | exc_req;
        new_rank   = RANK_BR;
        new_target = br_target;
        if (exc_req) begin
            new_rank   = RANK_EXC;
            new_target = EXC_VECTOR;
        end else if (eret_req) begin
            new_rank   = RANK_ERET;
            new_target = epc;
        end
    end

    // The stored redirect wins ties, so a new one must be strictly higher.
    assign new_beats_stored = new_valid && (new_rank > p_rank_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            p_rank_reg   <= RANK_BR;
            p_target_reg <= '0;
        end else begin
            state_reg    <= state_next;
            p_rank_reg   <= p_rank_next;
            p_target_reg <= p_target_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        p_rank_next   = p_rank_reg;
        p_target_next = p_target_reg;
        case (state_reg)
            IDLE: begin
                if (new_valid && stall) begin
                    state_next    = HOLD;
                    p_rank_next   = new_rank;
                    p_target_next = new_target;
                end
            end
            HOLD: begin
                if (stall) begin
                    if (new_beats_stored) begin
                        p_rank_next   = new_rank;
                        p_target_next = new_target;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // clr is suppressed under stall and reset; npc reads 0 whenever clr is low.
    always_comb begin
        clr      = 1'b0;
        npc      = '0;
        win_rank = RANK_BR;
        if (!reset && !stall) begin
            if (state_reg == HOLD) begin
                clr = 1'b1;
                if (new_beats_stored) begin
                    npc      = new_target;
                    win_rank = new_rank;
                end else begin
                    npc      = p_target_reg;
                    win_rank = p_rank_reg;
                end
            end else if (new_valid) begin
                clr      = 1'b1;
                npc      = new_target;
                win_rank = new_rank;
            end
        end
        flush_f = clr && (win_rank != RANK_BR);
    end

    assign pending = (state_reg == HOLD);

endmodule

// File: tb/tb_npc_redirect_ctrl.sv
// Scoreboard bench for npc_redirect_ctrl: driver pushes per-cycle expectations
// from a behavioural model, a negedge monitor pops and compares.
module tb_npc_redirect_ctrl;

    localparam int          AW  = 32;
    localparam logic [31:0] VEC = 32'h0000_4180;

    logic          clk = 1'b0;
    logic          reset, stall, br_req, exc_req, eret_req;
    logic [AW-1:0] br_target, epc;
    logic [AW-1:0] npc;
    logic          clr, flush_f, pending;

    npc_redirect_ctrl #(.AW(AW), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_req(br_req), .br_target(br_target),
        .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
        .npc(npc), .clr(clr), .flush_f(flush_f), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          check_pending;
        logic        clr;
        logic [31:0] npc;
        logic        flush;
        logic        pending;
    } exp_t;

    exp_t exp_q[$];
    int n_compared = 0;
    int n_mismatched = 0;
    int cyc = 0;

    // Behavioural model: one optional held redirect described by (rank, target).
    bit          held_valid = 0;
    int          held_rank  = 0;
    logic [31:0] held_target = 0;

    task automatic check(input string name, input int cy, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cy, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("clr", e.cyc, {31'd0, clr}, {31'd0, e.clr});
            check("npc", e.cyc, npc, e.npc);
            check("flush_f", e.cyc, {31'd0, flush_f}, {31'd0, e.flush});
            if (e.check_pending)
                check("pending", e.cyc, {31'd0, pending}, {31'd0, e.pending});
            if (e.clr)
                $display("cycle %0d redirect npc=%h flush_f=%0b", e.cyc, npc, flush_f);
        end
    end

    // Drive one cycle of inputs and push the expected response for that cycle.
    task automatic cycle(input bit rst, input bit stl, input bit br, input logic [31:0] bt,
                         input bit exc, input bit eret, input logic [31:0] ep);
        exp_t e;
        int          nrank;
        logic [31:0] ntgt;
        int          wrank;
        logic [31:0] wtgt;
        @(posedge clk);
        #1;
        reset = rst; stall = stl; br_req = br; br_target = bt;
        exc_req = exc; eret_req = eret; epc = ep;
        cyc++;
        e.cyc = cyc;
        e.check_pending = !rst;
        e.pending = held_valid;
        e.clr = 0; e.npc = 0; e.flush = 0;
        nrank = -1; ntgt = 0;
        if (br)   begin nrank = 0; ntgt = bt;  end
        if (eret) begin nrank = 1; ntgt = ep;  end
        if (exc)  begin nrank = 2; ntgt = VEC; end
        if (rst) begin
            held_valid = 0; held_rank = 0; held_target = 0;
        end else if (!stl) begin
            wrank = nrank; wtgt = ntgt;
            if (held_valid && held_rank >= nrank) begin
                wrank = held_rank; wtgt = held_target;
            end
            if (wrank >= 0) begin
                e.clr = 1; e.npc = wtgt; e.flush = (wrank > 0);
            end
            held_valid = 0;
        end else if (nrank >= 0 && (!held_valid || nrank > held_rank)) begin
            held_valid = 1; held_rank = nrank; held_target = ntgt;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input bit stl);
        cycle(0, stl, 0, 32'h0, 0, 0, 32'h0);
    endtask

    initial begin
        reset = 1; stall = 0; br_req = 0; exc_req = 0; eret_req = 0;
        br_target = 0; epc = 0;
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 32'h1111, 1, 0, 0);
        // 1: zero-latency branch
        cycle(0, 0, 1, 32'h3040, 0, 0, 0);
        idle(0);
        // 2: exception held across stall
        cycle(0, 1, 0, 0, 1, 0, 0);
        idle(1); idle(1); idle(1);
        idle(0); idle(0);
        // 3: eret overwrites held branch
        cycle(0, 1, 1, 32'h3100, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 32'h3200);
        idle(0); idle(0);
        // 4: simultaneous requests
        cycle(0, 0, 1, 32'h3300, 1, 1, 32'h3400);
        idle(0);
        // 5: reset discards held exception
        cycle(0, 1, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0);
        // 6: stored eret beats new branch on release
        cycle(0, 1, 0, 0, 0, 1, 32'h3500);
        cycle(0, 0, 1, 32'h3600, 0, 0, 0);
        idle(0);
        // equal-rank tie on release: stored exception keeps priority
        cycle(0, 1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        idle(0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 3) == 0), $urandom(),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom());
        end
        idle(0);
        repeat (3) @(posedge clk);
        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
